// File: rtl/cpu_paddle_driver.sv
// Computer-controlled Pong opponent: once per frame, drives the paddle's
// active-low up/down buttons toward a delayed, clamped copy of the ball Y.
module cpu_paddle_driver #(
  parameter int REACT_FRAMES = 4,
  parameter int MAX_STEP     = 3,
  parameter int DEADBAND     = 4,
  parameter int HOME_Y       = 240,
  parameter int MIN_CENTER   = 40,
  parameter int MAX_CENTER   = 439
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       frameTick,
  input  logic [9:0] ballYPos,
  input  logic       ballDirX,
  input  logic [9:0] paddleCenterYPos,
  output logic       upButton,
  output logic       downButton
);

  localparam int SW = $clog2(MAX_STEP + 1);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN} state_t;

  state_t         state;
  logic [9:0]     target;
  logic [3:0]     frame_cnt;
  logic [SW-1:0]  step_cnt;

  logic signed [10:0] err;
  logic [10:0]        mag;
  logic [SW-1:0]      n;
  logic [9:0]         load_val;
  logic               frame_wrap;

  // Error against the target held before this edge, burst length and next target.
  always_comb begin
    err        = $signed({1'b0, target}) - $signed({1'b0, paddleCenterYPos});
    mag        = err[10] ? (~err + 11'sd1) : err;
    n          = (mag > 11'(MAX_STEP)) ? SW'(MAX_STEP) : mag[SW-1:0];
    frame_wrap = (frame_cnt == 4'(REACT_FRAMES - 1));
    if (!ballDirX) begin
      load_val = 10'(HOME_Y);
    end else if (ballYPos < 10'(MIN_CENTER)) begin
      load_val = 10'(MIN_CENTER);
    end else if (ballYPos > 10'(MAX_CENTER)) begin
      load_val = 10'(MAX_CENTER);
    end else begin
      load_val = ballYPos;
    end
  end

  // Target tracking and burst FSM; buttons are registered and mutually exclusive.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      upButton   <= 1'b1;
      downButton <= 1'b1;
      target     <= 10'(HOME_Y);
      frame_cnt  <= 4'd0;
      step_cnt   <= '0;
    end else if (!enable) begin
      state      <= IDLE;
      upButton   <= 1'b1;
      downButton <= 1'b1;
      step_cnt   <= '0;
    end else begin
      if (frameTick) begin
        if (frame_wrap) begin
          frame_cnt <= 4'd0;
          target    <= load_val;
        end else begin
          frame_cnt <= frame_cnt + 4'd1;
        end
      end
      case (state)
        IDLE: begin
          upButton   <= 1'b1;
          downButton <= 1'b1;
          // mag above the deadband implies err is nonzero, so its sign picks the direction.
          if (frameTick && (mag > 11'(DEADBAND))) begin
            step_cnt <= n;
            if (!err[10]) begin
              state    <= MOVE_UP;
              upButton <= 1'b0;
            end else begin
              state      <= MOVE_DOWN;
              downButton <= 1'b0;
            end
          end
        end
        MOVE_UP: begin
          step_cnt   <= step_cnt - SW'(1);
          downButton <= 1'b1;
          if (step_cnt <= SW'(1)) begin
            state    <= IDLE;
            upButton <= 1'b1;
          end else begin
            upButton <= 1'b0;
          end
        end
        MOVE_DOWN: begin
          step_cnt <= step_cnt - SW'(1);
          upButton <= 1'b1;
          if (step_cnt <= SW'(1)) begin
            state      <= IDLE;
            downButton <= 1'b1;
          end else begin
            downButton <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          upButton   <= 1'b1;
          downButton <= 1'b1;
          step_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_paddle_driver.sv
// Bench for cpu_paddle_driver: directed scenarios plus random traffic, each
// cycle compared against a frame/burst model of the opponent's behaviour.
module tb_cpu_paddle_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       frameTick = 1'b0;
  logic [9:0] ballYPos = 10'd0;
  logic       ballDirX = 1'b0;
  logic [9:0] paddleCenterYPos = 10'd240;
  logic       upButton;
  logic       downButton;

  int errors = 0;
  int checks = 0;
  int up_low = 0;
  int down_low = 0;

  // Model state: target, frame count, remaining pressed cycles, direction.
  int m_target = 240;
  int m_frame  = 0;
  int m_left   = 0;
  bit m_up     = 1'b0;

  cpu_paddle_driver dut (
    .clk(clk), .reset(reset), .enable(enable), .frameTick(frameTick),
    .ballYPos(ballYPos), .ballDirX(ballDirX), .paddleCenterYPos(paddleCenterYPos),
    .upButton(upButton), .downButton(downButton)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge using the inputs applied before that edge.
  task automatic model_edge(input bit r, input bit e, input bit t);
    int err;
    int mag;
    int ld;
    if (r) begin
      m_target = 240; m_frame = 0; m_left = 0;
    end else if (!e) begin
      m_left = 0;
    end else begin
      err = m_target - int'(paddleCenterYPos);
      mag = (err < 0) ? -err : err;
      if (m_left > 0) m_left--;
      else if (t && mag > 4) begin
        m_left = (mag < 3) ? mag : 3;
        m_up   = (err > 0);
      end
      if (t) begin
        if (m_frame == 3) begin
          m_frame = 0;
          if (ballDirX) begin
            ld = int'(ballYPos);
            m_target = (ld < 40) ? 40 : (ld > 439) ? 439 : ld;
          end else begin
            m_target = 240;
          end
        end else begin
          m_frame++;
        end
      end
    end
  endtask

  task automatic step(input bit t, input bit e, input bit r);
    frameTick = t; enable = e; reset = r;
    @(posedge clk);
    model_edge(r, e, t);
    #1;
    check("up_button", int'(upButton), (m_left > 0 && m_up) ? 0 : 1);
    check("down_button", int'(downButton), (m_left > 0 && !m_up) ? 0 : 1);
    check("exclusive", int'(upButton | downButton), 1);
    if (upButton == 1'b0) up_low++;
    if (downButton == 1'b0) down_low++;
    frameTick = 1'b0; reset = 1'b0;
  endtask

  // One frame: tick on the first cycle, then quiet cycles.
  task automatic frame(input int pad);
    paddleCenterYPos = 10'(pad);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic clear_counts();
    up_low = 0; down_low = 0;
  endtask

  // Tick frames with the paddle parked on the target until a load has happened.
  task automatic load_target(input int ball, input bit dir);
    ballYPos = 10'(ball); ballDirX = dir;
    do frame(m_target); while (m_frame != 0);
  endtask

  initial begin
    step(1'b0, 1'b0, 1'b1);
    check("reset_up", int'(upButton), 1);
    check("reset_down", int'(downButton), 1);

    // Four ticks load target 300; the fifth produces a 3-cycle up burst.
    ballYPos = 10'd300; ballDirX = 1'b1;
    for (int k = 0; k < 4; k++) frame(240);
    check("target_after_4", m_target, 300);
    clear_counts();
    frame(240);
    check("burst_up_len", up_low, 3);
    check("burst_up_down", down_low, 0);

    // Within the deadband nothing is pressed.
    clear_counts();
    frame(298);
    check("deadband", up_low + down_low, 0);

    // Ball receding: target returns home, paddle above home moves down.
    load_target(300, 1'b0);
    clear_counts();
    frame(260);
    check("home_down_len", down_low, 3);
    check("home_down_up", up_low, 0);
    clear_counts();
    frame(242);
    check("home_deadband", up_low + down_low, 0);

    // Clamping at both ends.
    load_target(5, 1'b1);
    check("clamp_low", m_target, 40);
    clear_counts();
    frame(100);
    check("clamp_low_dir", down_low, 3);
    load_target(470, 1'b1);
    check("clamp_high", m_target, 439);
    clear_counts();
    frame(400);
    check("clamp_high_dir", up_low, 3);

    // Reset on the second pressed cycle aborts the burst.
    paddleCenterYPos = 10'd400;
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    check("reset_abort", int'(upButton & downButton), 1);
    check("reset_target", m_target, 240);
    frame(240);
    frame(240);

    // Disable mid-burst; ticks while disabled are ignored.
    load_target(470, 1'b1);
    paddleCenterYPos = 10'd400;
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("disable_abort", int'(upButton & downButton), 1);
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    check("disable_frame_hold", m_frame, 1);
    for (int k = 0; k < 4; k++) frame(int'(paddleCenterYPos));

    // A tick during a burst neither restarts nor extends it.
    load_target(470, 1'b1);
    clear_counts();
    paddleCenterYPos = 10'd400;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
    check("tick_in_burst", up_low, 3);

    // Random traffic.
    for (int i = 0; i < 1000; i++) begin
      ballYPos = 10'($urandom_range(0, 1023));
      ballDirX = 1'($urandom);
      paddleCenterYPos = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                                                     : 10'($urandom_range(30, 450));
      step(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 15) != 0),
           1'($urandom_range(0, 99) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_paddle_driver.md
Name: cpu_paddle_driver

Overview:
Computer-controlled opponent for the Pong datapath. Drives the active-low upButton/downButton inputs of a paddle instance, so it sits where the player's push-buttons would otherwise connect. Once per video frame it compares a tracked target Y against the paddle's reported center Y and emits a bounded burst of button presses. Reaction delay, deadband and per-frame speed cap are tunable difficulty knobs.

Parameters:
REACT_FRAMES, 4, target Y refreshed from ball Y only every REACT_FRAMES frameTicks (1..15)
MAX_STEP, 3, max button-asserted clk cycles per frame (paddle moves 1 px per asserted clk); must be less than frame length in clks
DEADBAND, 4, no movement when |target - paddle center| <= DEADBAND
HOME_Y, 240, recenter target while the ball moves away
MIN_CENTER, 40, lower clamp for target
MAX_CENTER, 439, upper clamp for target

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  1 = driver active; 0 = release both buttons
frameTick  in  1  single-clk pulse, once per frame
ballYPos  in  10  ball center Y, unsigned pixels
ballDirX  in  1  1 = ball approaching this paddle
paddleCenterYPos  in  10  feedback from the driven paddle
upButton  out  1  active low; low = paddle center Y increments each clk
downButton  out  1  active low; low = paddle center Y decrements each clk

Behaviour:
- Reset, sampled on the clk edge: upButton=1, downButton=1, state=IDLE, target=HOME_Y, frameCnt=0, stepCnt=0. Reset has priority over every other input, and aborts a burst mid-operation.
- Both outputs are registered. upButton and downButton are never low in the same cycle.
- Target register, updated on frameTick with enable=1 in any state:
  - frameCnt increments. When frameCnt==REACT_FRAMES-1, it wraps to 0 and target loads.
  - Load value: clamp(ballYPos, MIN_CENTER, MAX_CENTER) if ballDirX=1, else HOME_Y.
- Error evaluation uses the target value registered before the current edge. A same-cycle target load takes effect at the next frameTick.
  - err = target - paddleCenterYPos, computed as 11-bit signed; mag = |err|.
- States:
  - IDLE: outputs high.
    - On frameTick with enable=1 and mag > DEADBAND: n = min(mag, MAX_STEP), stepCnt <= n.
    - err > 0 goes to MOVE_UP, err < 0 goes to MOVE_DOWN.
    - Otherwise remain in IDLE.
  - MOVE_UP: upButton=0, downButton=1. stepCnt decrements each clk. When stepCnt reaches 0, go to IDLE with outputs high.
  - MOVE_DOWN: mirror of MOVE_UP using downButton.
- Latency and burst length:
  - frameTick at edge T: the first asserted button is visible after edge T.
  - The button stays low for exactly n cycles, then returns high.
- frameTick arriving during MOVE_*: the burst is not re-evaluated or extended. frameCnt and target still update.
- enable=0:
  - At the next edge: state=IDLE, both outputs 1, stepCnt=0.
  - frameTick is ignored and frameCnt holds.
  - Re-enabling resumes from the held frameCnt and target.
- Wall limits are owned by the paddle, which ignores presses at the playfield edges. The driver never targets outside [MIN_CENTER, MAX_CENTER].
- ballYPos >= 480 (off-screen): clamp yields MAX_CENTER. No special case.

Test Plan:
- Reset, then enable=1, paddle=240, ball Y=300, ballDirX=1, 4 frameTicks:
  - The 4th tick loads target=300. The 5th tick produces upButton low for exactly 3 clks, downButton high throughout.
- target=300, paddle=298 (mag 2 <= DEADBAND) at frameTick: both buttons stay high all frame.
- target=240 (ballDirX=0), paddle=260 at frameTick: downButton low exactly 3 clks, upButton high. With paddle=242 instead: no press.
- Ball Y=5, ballDirX=1 after load: target=40. Ball Y=470: target=439. Verify the burst direction toward the clamp value.
- Mid-burst (second asserted clk) assert reset: both outputs high on the next edge, frameCnt=0, target=240. Repeat with enable=0 instead: outputs high next edge, and frameTicks during enable=0 do not advance frameCnt.
- frameTick pulsed during a MOVE_UP burst: burst length unchanged (3 clks). Across 1000 random cycles, assert never (upButton==0 && downButton==0).
